// File: rtl/bin2ascii_dabble_pkg.sv
// Shared constants, FSM state type and helpers for the binary-to-ASCII LCD field path.
package lcd_pkg;

   localparam logic [7:0] ASCII_ZERO  = 8'h30;
   localparam logic [7:0] ASCII_NINE  = 8'h39;
   localparam logic [7:0] ASCII_SPACE = 8'h20;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      FORMAT = 2'd2,
      DONE   = 2'd3
   } state_t;

   // Elaboration-time power of ten; used only to build constant compare limits.
   function automatic logic [63:0] pow10(input int n);
      logic [63:0] r;
      r = 64'd1;
      for (int i = 0; i < n; i++) begin
         r = r * 64'd10;
      end
      return r;
   endfunction

endpackage

// File: rtl/bin2ascii_dabble_if.sv
// Request/result bundle between a sample source and the bin2ascii_dabble converter.
interface bin2ascii_dabble_if #(
   parameter int IN_W   = 20,
   parameter int DIGITS = 6
);
   logic [IN_W-1:0]       bin_in;
   logic                  start;
   logic                  busy;
   logic                  done;
   logic [8*DIGITS-1:0]   ascii_out;
   logic                  overflow;

   modport master (
      output bin_in, start,
      input  busy, done, ascii_out, overflow
   );

   modport slave (
      input  bin_in, start,
      output busy, done, ascii_out, overflow
   );
endinterface

// File: rtl/bin2ascii_dabble_adj3.sv
// One double-dabble correction cell: a BCD nibble of 5 or more gets +3 before the shift.
module dabble_adj3 (
   input  logic [3:0] nib,
   output logic [3:0] adj
);
   assign adj = (nib >= 4'd5) ? nib + 4'd3 : nib;
endmodule

// File: rtl/bin2ascii_dabble.sv
// Iterative double-dabble binary to fixed-width ASCII decimal field for the LCD driver.
// Optional: define BIN2ASCII_LEADING_BLANK_EN to replace leading zeros with spaces.
module bin2ascii_dabble
   import lcd_pkg::*;
#(
   parameter int IN_W   = 20,
   parameter int DIGITS = 6
) (
   input  logic               clk_5ms,
   input  logic               rst_n,
   bin2ascii_dabble_if.slave  bus
);
   localparam int BCD_W = 4 * DIGITS;
   localparam int OUT_W = 8 * DIGITS;
   localparam int CNT_W = $clog2(IN_W + 1);
   localparam logic [63:0] LIMIT = pow10(DIGITS) - 64'd1;

   state_t                  state_reg, state_next;
   logic [IN_W-1:0]         bin_reg;
   logic [BCD_W-1:0]        bcd_reg;
   logic [BCD_W-1:0]        bcd_adj;
   logic [CNT_W-1:0]        cnt_reg;
   logic                    ovf_pend_reg;
   logic [OUT_W-1:0]        ascii_reg;
   logic [OUT_W-1:0]        ascii_fmt;
   logic                    ovf_reg;
   logic                    busy_c;
   logic                    done_c;
   logic [BCD_W+IN_W-1:0]   shift_next;

   generate
      for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
         dabble_adj3 u_adj (
            .nib (bcd_reg[4*gi +: 4]),
            .adj (bcd_adj[4*gi +: 4])
         );
      end
   endgenerate

   assign shift_next = {bcd_adj, bin_reg} << 1;

   always_ff @(posedge clk_5ms or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      busy_c     = 1'b0;
      done_c     = 1'b0;
      case (state_reg)
         IDLE: begin
            if (bus.start) begin
               state_next = SHIFT;
            end
         end
         SHIFT: begin
            busy_c = 1'b1;
            if (cnt_reg == CNT_W'(1)) begin
               state_next = FORMAT;
            end
         end
         FORMAT: begin
            busy_c     = 1'b1;
            state_next = DONE;
         end
         DONE: begin
            busy_c     = 1'b1;
            done_c     = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
`ifdef BIN2ASCII_LEADING_BLANK_EN
      logic lead;
`endif
      ascii_fmt = '0;
      for (int i = 0; i < DIGITS; i++) begin
         ascii_fmt[8*i +: 8] = ASCII_ZERO + {4'h0, bcd_reg[4*i +: 4]};
      end
`ifdef BIN2ASCII_LEADING_BLANK_EN
      // Digit 0 is never blanked so a zero value still shows one numeral.
      lead = 1'b1;
      for (int i = DIGITS - 1; i > 0; i--) begin
         if (lead && (bcd_reg[4*i +: 4] == 4'h0)) begin
            ascii_fmt[8*i +: 8] = ASCII_SPACE;
         end else begin
            lead = 1'b0;
         end
      end
`endif
      if (ovf_pend_reg) begin
         ascii_fmt = {DIGITS{ASCII_NINE}};
      end
   end

   always_ff @(posedge clk_5ms or negedge rst_n) begin
      if (!rst_n) begin
         bin_reg      <= '0;
         bcd_reg      <= '0;
         cnt_reg      <= '0;
         ovf_pend_reg <= 1'b0;
         ascii_reg    <= {DIGITS{ASCII_ZERO}};
         ovf_reg      <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (bus.start) begin
                  bin_reg      <= bus.bin_in;
                  bcd_reg      <= '0;
                  cnt_reg      <= CNT_W'(IN_W);
                  ovf_pend_reg <= (64'(bus.bin_in) > LIMIT);
               end
            end
            SHIFT: begin
               {bcd_reg, bin_reg} <= shift_next;
               cnt_reg            <= cnt_reg - CNT_W'(1);
            end
            FORMAT: begin
               // Results land together with the done pulse; no partial field is ever visible.
               ascii_reg <= ascii_fmt;
               ovf_reg   <= ovf_pend_reg;
            end
            default: ;
         endcase
      end
   end

   assign bus.busy      = busy_c;
   assign bus.done      = done_c;
   assign bus.ascii_out = ascii_reg;
   assign bus.overflow  = ovf_reg;

endmodule

// File: tb/tb_bin2ascii_dabble.sv
// Self-checking bench: randomized and directed conversions against a behavioural decimal model.
`timescale 1us/1ns
module tb_bin2ascii_dabble;
   localparam int IN_W   = 20;
   localparam int DIGITS = 6;
   localparam int LAT    = IN_W + 2;
   localparam int unsigned LIM = 10**DIGITS - 1;

   logic clk_5ms = 1'b0;
   logic rst_n   = 1'b1;
   logic chk_en  = 1'b0;
   int   tests   = 0;
   int   fails   = 0;

   always #2500 clk_5ms = ~clk_5ms;

   bin2ascii_dabble_if #(.IN_W(IN_W), .DIGITS(DIGITS)) bus ();

   bin2ascii_dabble #(.IN_W(IN_W), .DIGITS(DIGITS)) dut (
      .clk_5ms (clk_5ms),
      .rst_n   (rst_n),
      .bus     (bus)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Decimal field from plain arithmetic: digits by repeated /10, saturation above LIM.
   function automatic logic [8*DIGITS-1:0] model_field(input int unsigned v);
      logic [8*DIGITS-1:0] f;
      int unsigned t;
      int nd;
      if (v > LIM) begin
         f = {DIGITS{8'h39}};
      end else begin
         t = v;
         for (int k = 0; k < DIGITS; k++) begin
            f[8*k +: 8] = 8'h30 + 8'(t % 10);
            t = t / 10;
         end
`ifdef BIN2ASCII_LEADING_BLANK_EN
         t  = v;
         nd = 1;
         while (t >= 10) begin
            t = t / 10;
            nd++;
         end
         for (int k = nd; k < DIGITS; k++) begin
            f[8*k +: 8] = 8'h20;
         end
`else
         nd = 0;
`endif
      end
      return f;
   endfunction

   // Model timeline: age 0 = idle, 1..LAT = cycles since acceptance; LAT is the done cycle.
   int                  age = 0;
   int unsigned         m_val = 0;
   logic [8*DIGITS-1:0] m_ascii = {DIGITS{8'h30}};
   logic                m_ovf = 1'b0;

   always @(posedge clk_5ms or negedge rst_n) begin
      if (!rst_n) begin
         age     <= 0;
         m_ascii <= {DIGITS{8'h30}};
         m_ovf   <= 1'b0;
      end else if (age == 0) begin
         if (bus.start) begin
            age   <= 1;
            m_val <= 32'(bus.bin_in);
         end
      end else if (age == LAT) begin
         age <= 0;
      end else begin
         age <= age + 1;
         if (age == LAT - 1) begin
            m_ascii <= model_field(m_val);
            m_ovf   <= (m_val > LIM);
         end
      end
   end

   always @(negedge clk_5ms) begin
      if (chk_en) begin
         check("busy", 64'(bus.busy), 64'(age != 0));
         check("done", 64'(bus.done), 64'(age == LAT));
         check("ascii_out", 64'(bus.ascii_out), 64'(m_ascii));
         check("overflow", 64'(bus.overflow), 64'(m_ovf));
      end
   end

   task automatic run_one(input logic [IN_W-1:0] v, output int lat);
      @(negedge clk_5ms);
      bus.bin_in = v;
      bus.start  = 1'b1;
      lat = 0;
      do begin
         @(negedge clk_5ms);
         lat++;
         if (lat == 1) bus.start = 1'b0;
      end while (!bus.done && lat < 60);
      check("done_seen", 64'(bus.done), 64'd1);
      $display("[TB] conv in=%0d lat=%0d ascii=%h ovf=%0b", v, lat, bus.ascii_out, bus.overflow);
   endtask

   task automatic count_dones(input int cycles, output int n);
      n = 0;
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk_5ms);
         if (bus.done) n++;
      end
   endtask

   int lat, n, low;
   logic [8*DIGITS-1:0] exp7, exp500;

   initial begin
`ifdef BIN2ASCII_LEADING_BLANK_EN
      exp7   = 48'h202020202037;
      exp500 = 48'h202020353030;
`else
      exp7   = 48'h303030303037;
      exp500 = 48'h303030353030;
`endif
      bus.start  = 1'b0;
      bus.bin_in = '0;
      #1 rst_n = 1'b0;
      chk_en = 1'b1;
      repeat (3) @(negedge clk_5ms);
      #1000 rst_n = 1'b1;
      @(negedge clk_5ms);
      check("rst_ascii", 64'(bus.ascii_out), 64'h303030303030);
      check("rst_busy", 64'(bus.busy), 64'd0);
      check("rst_done", 64'(bus.done), 64'd0);
      check("rst_ovf", 64'(bus.overflow), 64'd0);

      run_one(20'd123456, lat);
      check("lat_123456", 64'(lat), 64'(LAT));
      check("ascii_123456", 64'(bus.ascii_out), 64'h313233343536);
      check("ovf_123456", 64'(bus.overflow), 64'd0);

      // Back-to-back with start held high.
      @(negedge clk_5ms);
      bus.bin_in = 20'd0;
      bus.start  = 1'b1;
      n = 0;
      do begin
         @(negedge clk_5ms);
         n++;
         if (n == 1) bus.bin_in = 20'd999999;
      end while (!bus.done && n < 60);
      check("lat_zero", 64'(n), 64'(LAT));
      check("ascii_zero", 64'(bus.ascii_out), 64'(model_field(0)));
      n = 0;
      low = 0;
      do begin
         @(negedge clk_5ms);
         n++;
         if (!bus.busy) low++;
      end while (!bus.done && n < 60);
      bus.start = 1'b0;
      check("b2b_gap", 64'(n), 64'(LAT + 1));
      check("b2b_busy_low", 64'(low), 64'd1);
      check("ascii_999999", 64'(bus.ascii_out), 64'h393939393939);
      check("ovf_999999", 64'(bus.overflow), 64'd0);
      $display("[TB] b2b gap=%0d busy_low=%0d ascii=%h", n, low, bus.ascii_out);

      run_one(20'hFFFFF, lat);
      check("ascii_sat", 64'(bus.ascii_out), 64'h393939393939);
      check("ovf_sat", 64'(bus.overflow), 64'd1);
      run_one(20'd7, lat);
      check("ascii_7", 64'(bus.ascii_out), 64'(exp7));
      check("ovf_7", 64'(bus.overflow), 64'd0);

      // Second request while busy must be dropped.
      @(negedge clk_5ms);
      bus.bin_in = 20'd500;
      bus.start  = 1'b1;
      @(negedge clk_5ms);
      bus.start = 1'b0;
      repeat (4) @(negedge clk_5ms);
      bus.bin_in = 20'd42;
      bus.start  = 1'b1;
      @(negedge clk_5ms);
      bus.start = 1'b0;
      count_dones(40, n);
      check("ignored_dones", 64'(n), 64'd1);
      check("ascii_500", 64'(bus.ascii_out), 64'(exp500));
      $display("[TB] ignored-start dones=%0d ascii=%h", n, bus.ascii_out);

      // Reset in SHIFT cycle 10.
      @(negedge clk_5ms);
      bus.bin_in = 20'd654321;
      bus.start  = 1'b1;
      @(negedge clk_5ms);
      bus.start = 1'b0;
      repeat (9) @(negedge clk_5ms);
      #1000 rst_n = 1'b0;
      @(negedge clk_5ms);
      check("midrst_ascii", 64'(bus.ascii_out), 64'h303030303030);
      check("midrst_busy", 64'(bus.busy), 64'd0);
      check("midrst_done", 64'(bus.done), 64'd0);
      check("midrst_ovf", 64'(bus.overflow), 64'd0);
      #1000 rst_n = 1'b1;
      count_dones(30, n);
      check("midrst_no_done", 64'(n), 64'd0);
      $display("[TB] mid-conversion reset dones=%0d", n);
      run_one(20'd654321, lat);
      check("ascii_654321", 64'(bus.ascii_out), 64'h363534333231);

      // Randomized conversions with noisy start/bin_in while busy.
      for (int it = 0; it < 25; it++) begin
         logic [IN_W-1:0] v;
         case ($urandom_range(0, 3))
            0:       v = 20'($urandom_range(0, 99));
            1:       v = 20'($urandom_range(0, 999999));
            2:       v = 20'($urandom);
            default: v = 20'($urandom_range(999990, 1000010));
         endcase
         run_one(v, lat);
         check("rand_lat", 64'(lat), 64'(LAT));
         repeat ($urandom_range(0, 30)) begin
            @(negedge clk_5ms);
            bus.start  = ($urandom_range(0, 3) == 0);
            bus.bin_in = 20'($urandom);
         end
         bus.start = 1'b0;
         repeat (LAT + 2) @(negedge clk_5ms);
      end

      chk_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
